// File: rtl/tick_sched_pkg.sv
// Shared types and default sizing for the tick scheduler and its channels.
package tick_sched_pkg;

    typedef enum logic {
        CFG_IDLE  = 1'b0,
        CFG_APPLY = 1'b1
    } cfg_state_t;

    localparam int TS_NUM_CH   = 4;
    localparam int TS_PRESCALE = 100;
    localparam int TS_PERIOD_W = 16;

endpackage

// File: rtl/tick_channel.sv
// One scheduler channel: holds its period, run flag and strobe counter, and
// emits a registered one-cycle tick every period base strobes.
module tick_channel
    import tick_sched_pkg::*;
#(
    parameter int PERIOD_W = TS_PERIOD_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                strobe,
    input  logic                load,
    input  logic [PERIOD_W-1:0] load_period,
    input  logic                load_run,
    output logic                tick,
    output logic                running
);

    logic [PERIOD_W-1:0] r_period;
    logic [PERIOD_W-1:0] r_cnt;
    logic                r_run;
    logic                r_tick;

    // A load overrides a coincident strobe, so a reconfigured channel always
    // restarts its count cleanly and never ticks on the apply edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_period <= '0;
            r_cnt    <= '0;
            r_run    <= 1'b0;
            r_tick   <= 1'b0;
        end else if (load) begin
            r_period <= load_period;
            r_run    <= load_run && (load_period != '0);
            r_cnt    <= '0;
            r_tick   <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (strobe && r_run) begin
                if (r_cnt == r_period - 1'b1) begin
                    r_tick <= 1'b1;
                    r_cnt  <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign tick    = r_tick;
    assign running = r_run;

endmodule

// File: rtl/tick_scheduler.sv
// Shared clock-enable scheduler: one prescaler producing a base strobe, a
// two-state configuration port, and NUM_CH independent tick channels.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// CFG_IDLE  | cfg_ready high, waiting for a cfg_valid transfer
// CFG_APPLY | latched config is written into its channel this edge
module tick_scheduler
    import tick_sched_pkg::*;
#(
    parameter  int NUM_CH   = TS_NUM_CH,
    parameter  int PRESCALE = TS_PRESCALE,
    parameter  int PERIOD_W = TS_PERIOD_W,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic                cfg_run,
    output logic [NUM_CH-1:0]   tick,
    output logic [NUM_CH-1:0]   running,
    output logic                base_tick
);

    localparam int P_W = $clog2(PRESCALE);

    logic [P_W-1:0]      r_p;
    logic                r_base_tick;
    cfg_state_t          r_state;
    cfg_state_t          w_next;
    logic [CH_W-1:0]     r_lat_ch;
    logic [PERIOD_W-1:0] r_lat_period;
    logic                r_lat_run;
    logic                w_strobe;
    logic                w_xfer;
    logic                w_apply;

    assign w_strobe = enable && (r_p == P_W'(PRESCALE - 1));

    // Prescaler: free-running while enabled, frozen (not cleared) otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_p <= '0;
        end else if (w_strobe) begin
            r_p <= '0;
        end else if (enable) begin
            r_p <= r_p + 1'b1;
        end
    end

    // Registered copy of the strobe for downstream users.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_base_tick <= 1'b0;
        end else begin
            r_base_tick <= w_strobe;
        end
    end

    // Ready is held low while reset is asserted so nothing handshakes then.
    assign cfg_ready = (r_state == CFG_IDLE) && reset;
    assign w_xfer    = cfg_valid && cfg_ready;
    assign w_apply   = (r_state == CFG_APPLY);

    // Config FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= CFG_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Config FSM next state: every accepted transfer spends exactly one APPLY cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            CFG_IDLE:  if (w_xfer) w_next = CFG_APPLY;
            CFG_APPLY: w_next = CFG_IDLE;
            default:   w_next = CFG_IDLE;
        endcase
    end

    // Capture the request on the transfer edge so the bus may change afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lat_ch     <= '0;
            r_lat_period <= '0;
            r_lat_run    <= 1'b0;
        end else if (w_xfer) begin
            r_lat_ch     <= cfg_ch;
            r_lat_period <= cfg_period;
            r_lat_run    <= cfg_run;
        end
    end

    // An out-of-range channel index matches no instance, making APPLY a no-op.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        tick_channel #(
            .PERIOD_W (PERIOD_W)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .strobe      (w_strobe),
            .load        (w_apply && (r_lat_ch == CH_W'(g))),
            .load_period (r_lat_period),
            .load_run    (r_lat_run),
            .tick        (tick[g]),
            .running     (running[g])
        );
    end

    assign base_tick = r_base_tick;

endmodule

// File: tb/tb_tick_scheduler.sv
// Self-checking bench for tick_scheduler with a strobe-counting reference model.
module tb_tick_scheduler;

    localparam int NUM_CH   = 5;
    localparam int PRESCALE = 4;
    localparam int PERIOD_W = 16;
    localparam int VW       = 2 * NUM_CH + 2;

    logic                clk = 1'b0;
    logic                reset;
    logic                enable;
    logic                cfg_valid;
    logic                cfg_ready;
    logic [2:0]          cfg_ch;
    logic [PERIOD_W-1:0] cfg_period;
    logic                cfg_run;
    logic [NUM_CH-1:0]   tick;
    logic [NUM_CH-1:0]   running;
    logic                base_tick;

    int n_cmp  = 0;
    int n_fail = 0;

    tick_scheduler #(
        .NUM_CH   (NUM_CH),
        .PRESCALE (PRESCALE),
        .PERIOD_W (PERIOD_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .cfg_run    (cfg_run),
        .tick       (tick),
        .running    (running),
        .base_tick  (base_tick)
    );

    always #5 clk = ~clk;

    // Reference model: strobes counted from enabled cycles, ticks from strobes since apply.
    int                m_encnt;
    bit                m_pend;
    int                m_lch, m_lp;
    bit                m_lr;
    int                m_per [NUM_CH];
    int                m_sc  [NUM_CH];
    logic [NUM_CH-1:0] m_tick, m_run;
    logic              m_base;

    always @(posedge clk or negedge reset) begin
        bit s;
        if (!reset) begin
            m_encnt = 0; m_pend = 0; m_lch = 0; m_lp = 0; m_lr = 0;
            m_tick = '0; m_run = '0; m_base = 0;
            for (int i = 0; i < NUM_CH; i++) begin m_per[i] = 0; m_sc[i] = 0; end
        end else begin
            s = enable && ((m_encnt % PRESCALE) == PRESCALE - 1);
            m_base = s;
            for (int i = 0; i < NUM_CH; i++) begin
                m_tick[i] = 1'b0;
                if (m_pend && m_lch == i) begin
                    m_per[i] = m_lp;
                    m_run[i] = m_lr && (m_lp != 0);
                    m_sc[i]  = 0;
                end else if (s && m_run[i]) begin
                    m_sc[i]++;
                    if (m_sc[i] % m_per[i] == 0) m_tick[i] = 1'b1;
                end
            end
            if (m_pend) m_pend = 0;
            else if (cfg_valid) begin
                m_pend = 1; m_lch = int'(cfg_ch); m_lp = int'(cfg_period); m_lr = cfg_run;
            end
            if (enable) m_encnt++;
        end
    end

    // Tick timestamp recorder (cycle numbers), sampled 1 ns after each edge.
    int cyc = 0;
    int q0[$], q1[$], q2[$], qb[$];
    always @(posedge clk) begin
        #1;
        cyc++;
        if (tick[0]) q0.push_back(cyc);
        if (tick[1]) q1.push_back(cyc);
        if (tick[2]) q2.push_back(cyc);
        if (base_tick) qb.push_back(cyc);
    end

    // Issue one configuration transfer; returns at the negedge before APPLY.
    task automatic send_cfg(input int ch, input int per, input bit run);
        int guard = 0;
        while (m_pend && guard < 10) begin @(negedge clk); guard++; end
        cfg_valid  = 1'b1;
        cfg_ch     = 3'(ch);
        cfg_period = 16'(per);
        cfg_run    = run;
        @(negedge clk);
        cfg_valid  = 1'b0;
    endtask

    task automatic test_reset();
        logic [VW-1:0] act, exp;
        reset = 1'b0; enable = 1'b1; cfg_valid = 1'b0;
        cfg_ch = '0; cfg_period = '0; cfg_run = 1'b0;
        repeat (5) begin
            @(negedge clk);
            n_cmp++;
            if ({tick, running, base_tick, cfg_ready} !== '0) begin
                n_fail++;
                $display("FAIL reset_hold: got %h expected 0", {tick, running, base_tick, cfg_ready});
            end
        end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (cfg_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b expected 1", cfg_ready);
        end
        repeat (100) begin
            @(negedge clk);
            act = {tick, running, base_tick, cfg_ready};
            exp = {m_tick, m_run, m_base, reset && !m_pend};
            n_cmp++;
            if (tick !== '0 || act !== exp) begin
                n_fail++; $display("FAIL reset_idle: got %h expected %h", act, exp);
            end
        end
    endtask

    task automatic test_basic_rate();
        logic [VW-1:0] act, exp;
        send_cfg(0, 3, 1'b1);
        @(negedge clk);
        n_cmp++;
        if (running[0] !== 1'b1) begin
            n_fail++; $display("FAIL basic_running: got %b expected 1", running[0]);
        end
        q0.delete(); qb.delete();
        repeat (80) begin
            @(negedge clk);
            act = {tick, running, base_tick, cfg_ready};
            exp = {m_tick, m_run, m_base, reset && !m_pend};
            n_cmp++;
            if (act !== exp) begin
                n_fail++; $display("FAIL basic_model: got %h expected %h", act, exp);
            end
        end
        n_cmp++;
        if (q0.size() < 5) begin
            n_fail++; $display("FAIL basic_count: got %0d ticks expected >= 5", q0.size());
        end
        for (int k = 1; k < q0.size(); k++) begin
            n_cmp++;
            if (q0[k] - q0[k-1] != 12) begin
                n_fail++; $display("FAIL basic_spacing: got %0d expected 12", q0[k] - q0[k-1]);
            end
        end
        for (int k = 1; k < qb.size(); k++) begin
            n_cmp++;
            if (qb[k] - qb[k-1] != 4) begin
                n_fail++; $display("FAIL base_spacing: got %0d expected 4", qb[k] - qb[k-1]);
            end
        end
    endtask

    task automatic test_multi();
        logic [VW-1:0] act, exp;
        q0.delete(); q1.delete(); q2.delete();
        for (int step = 0; step < 2; step++) begin
            if (step == 0) send_cfg(1, 1, 1'b1);
            else           send_cfg(2, 5, 1'b1);
            repeat (step == 0 ? 24 : 90) begin
                @(negedge clk);
                act = {tick, running, base_tick, cfg_ready};
                exp = {m_tick, m_run, m_base, reset && !m_pend};
                n_cmp++;
                if (act !== exp) begin
                    n_fail++; $display("FAIL multi_model: got %h expected %h", act, exp);
                end
            end
        end
        n_cmp++;
        if (q2.size() < 3 || q1.size() < 10) begin
            n_fail++; $display("FAIL multi_count: got ch1=%0d ch2=%0d expected >=10 >=3", q1.size(), q2.size());
        end
        for (int k = 1; k < q0.size(); k++) begin
            n_cmp++;
            if (q0[k] - q0[k-1] != 12) begin
                n_fail++; $display("FAIL multi_ch0_spacing: got %0d expected 12", q0[k] - q0[k-1]);
            end
        end
        for (int k = 1; k < q1.size(); k++) begin
            n_cmp++;
            if (q1[k] - q1[k-1] != 4) begin
                n_fail++; $display("FAIL multi_ch1_spacing: got %0d expected 4", q1[k] - q1[k-1]);
            end
        end
        for (int k = 1; k < q2.size(); k++) begin
            n_cmp++;
            if (q2[k] - q2[k-1] != 20) begin
                n_fail++; $display("FAIL multi_ch2_spacing: got %0d expected 20", q2[k] - q2[k-1]);
            end
        end
    endtask

    task automatic test_collision();
        logic [VW-1:0] act, exp;
        int guard = 0;
        int found = -1;
        while (!(m_encnt % PRESCALE == PRESCALE - 2 && m_sc[0] % 3 == 2 && !m_pend) && guard < 200) begin
            @(negedge clk); guard++;
        end
        n_cmp++;
        if (guard >= 200) begin
            n_fail++; $display("FAIL collision_setup: got timeout expected alignment");
        end
        send_cfg(0, 3, 1'b1);
        @(negedge clk);
        n_cmp++;
        if (tick[0] !== 1'b0 || base_tick !== 1'b1) begin
            n_fail++; $display("FAIL collision_tick: got tick0=%b base=%b expected 0 1", tick[0], base_tick);
        end
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            act = {tick, running, base_tick, cfg_ready};
            exp = {m_tick, m_run, m_base, reset && !m_pend};
            n_cmp++;
            if (act !== exp) begin
                n_fail++; $display("FAIL collision_model: got %h expected %h", act, exp);
            end
            if (tick[0] && found < 0) found = k;
        end
        n_cmp++;
        if (found != 12) begin
            n_fail++; $display("FAIL collision_next: got %0d cycles expected 12", found);
        end
    endtask

    task automatic test_stop_enable();
        logic [VW-1:0] act, exp;
        int guard = 0;
        int k = 0;
        send_cfg(0, 0, 1'b1);
        @(negedge clk);
        n_cmp++;
        if (running[0] !== 1'b0) begin
            n_fail++; $display("FAIL stop_running: got %b expected 0", running[0]);
        end
        repeat (40) begin
            @(negedge clk);
            act = {tick, running, base_tick, cfg_ready};
            exp = {m_tick, m_run, m_base, reset && !m_pend};
            n_cmp++;
            if (tick[0] !== 1'b0 || act !== exp) begin
                n_fail++; $display("FAIL stop_quiet: got %h expected %h", act, exp);
            end
        end
        while (tick[1] !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
        enable = 1'b0;
        repeat (10) begin
            @(negedge clk);
            n_cmp++;
            if (tick !== '0 || base_tick !== 1'b0) begin
                n_fail++; $display("FAIL disable_quiet: got tick=%h base=%b expected 0 0", tick, base_tick);
            end
        end
        enable = 1'b1;
        while (tick[1] !== 1'b1 && k < 30) begin
            @(negedge clk); k++;
            act = {tick, running, base_tick, cfg_ready};
            exp = {m_tick, m_run, m_base, reset && !m_pend};
            n_cmp++;
            if (act !== exp) begin
                n_fail++; $display("FAIL enable_model: got %h expected %h", act, exp);
            end
        end
        n_cmp++;
        if (10 + k != 14) begin
            n_fail++; $display("FAIL enable_spacing: got %0d cycles expected 14", 10 + k);
        end
    endtask

    task automatic test_back_to_back();
        logic [VW-1:0] act, exp;
        int chs [5] = '{3, 7, 4, 4, 2};
        int pers[5] = '{2, 5, 7, 1, 4};
        bit runs[5] = '{1, 0, 1, 1, 1};
        bit exp_r = 1'b1;
        int idx = 0;
        int guard = 0;
        while (m_pend && guard < 10) begin @(negedge clk); guard++; end
        cfg_valid = 1'b1; cfg_ch = 3'(chs[0]); cfg_period = 16'(pers[0]); cfg_run = runs[0];
        for (int c = 0; c < 10; c++) begin
            n_cmp++;
            if (cfg_ready !== exp_r) begin
                n_fail++; $display("FAIL handshake_ready: got %b expected %b", cfg_ready, exp_r);
            end
            @(negedge clk);
            exp_r = !exp_r;
            if (!exp_r) begin
                idx++;
                if (idx < 5) begin
                    cfg_ch = 3'(chs[idx]); cfg_period = 16'(pers[idx]); cfg_run = runs[idx];
                end else begin
                    cfg_valid = 1'b0;
                end
            end
        end
        n_cmp++;
        if (running !== 5'b11110) begin
            n_fail++; $display("FAIL handshake_running: got %b expected 11110", running);
        end
        repeat (60) begin
            @(negedge clk);
            act = {tick, running, base_tick, cfg_ready};
            exp = {m_tick, m_run, m_base, reset && !m_pend};
            n_cmp++;
            if (act !== exp) begin
                n_fail++; $display("FAIL handshake_model: got %h expected %h", act, exp);
            end
        end
    endtask

    task automatic test_reset_mid_apply();
        logic [VW-1:0] act, exp;
        send_cfg(0, 2, 1'b1);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({tick, running, base_tick, cfg_ready} !== '0) begin
            n_fail++; $display("FAIL midapply_reset: got %h expected 0", {tick, running, base_tick, cfg_ready});
        end
        reset = 1'b1;
        repeat (30) begin
            @(negedge clk);
            act = {tick, running, base_tick, cfg_ready};
            exp = {m_tick, m_run, m_base, reset && !m_pend};
            n_cmp++;
            if (running[0] !== 1'b0 || act !== exp) begin
                n_fail++; $display("FAIL midapply_lost: got %h expected %h", act, exp);
            end
        end
    endtask

    task automatic test_random();
        logic [VW-1:0] act, exp;
        repeat (500) begin
            @(negedge clk);
            act = {tick, running, base_tick, cfg_ready};
            exp = {m_tick, m_run, m_base, reset && !m_pend};
            n_cmp++;
            if (act !== exp) begin
                n_fail++; $display("FAIL random_model: got %h expected %h", act, exp);
            end
            enable     = ($urandom % 10) != 0;
            cfg_valid  = ($urandom % 5) == 0;
            cfg_ch     = 3'($urandom % 8);
            cfg_period = 16'($urandom % 5);
            cfg_run    = ($urandom % 4) != 0;
        end
        cfg_valid = 1'b0;
        enable    = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        test_reset();
        test_basic_rate();
        test_multi();
        test_collision();
        test_stop_enable();
        test_back_to_back();
        test_reset_mid_apply();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
